cbm_issue_arbiter: RTL

- Shares one column_bypass_multiplier (CBM) instance between the two issue pipes (pipe 0, pipe 1) of the dual-issue core.
- Accepts MUL requests over valid/ready handshakes and arbitrates them round-robin.
- Sequences the CBM start/busy/done protocol, holds the result until the owning pipe accepts it, and supports pipeline flush.
- Sits between the issue stage and the CBM; writeback consumes its response ports.

---
 rtl/cbm_issue_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cbm_issue_arbiter.sv
// cbm_issue_arbiter
//   Shares one column_bypass_multiplier (CBM) between the two issue pipes of
//   the dual-issue core. Requests from pipe 0 and pipe 1 arrive over
//   valid/ready handshakes and are granted round-robin. A granted request is
//   issued to the CBM with a one-cycle start pulse. The product is held on
//   the rsp_* port until writeback accepts it. A flush squashes any
//   in-flight or pending multiply.
//
// Ports
//   clk_i, rst_i                   core clock, asynchronous active-high reset
//   req{0,1}_valid_i/_ready_o      per-pipe request handshake
//   req{0,1}_a_i/_b_i/_rd_i        per-pipe operands and destination index
//   flush_i                        squash in-flight / pending multiply
//   rsp_valid_o/rsp_ready_i        result handshake towards writeback
//   rsp_pipe_o/rsp_rd_o/rsp_data_o owning pipe, destination, low product bits
//   cbm_start_o                    one-cycle start pulse to the CBM
//   cbm_a_o/cbm_b_o/cbm_rd_o       registered operands and tag to the CBM
//   cbm_busy_i/cbm_done_i          CBM status
//   cbm_result_i/cbm_rd_i          CBM result and returned tag (done cycle)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no multiply owned; grant one pipe when the CBM is free
// ISSUE | start pulse on the CBM with operands stable
// WAIT  | CBM computing; capture result on done
// RESP  | result held on rsp_* until writeback accepts it
// DRAIN | flushed op still inside the CBM; discard its done

module cbm_issue_arbiter #(
    parameter int RD_W   = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    input  logic [RD_W-1:0]   req0_rd_i,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    input  logic [RD_W-1:0]   req1_rd_i,

    input  logic              flush_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_pipe_o,
    output logic [RD_W-1:0]   rsp_rd_o,
    output logic [DATA_W-1:0] rsp_data_o,

    output logic              cbm_start_o,
    output logic [DATA_W-1:0] cbm_a_o,
    output logic [DATA_W-1:0] cbm_b_o,
    output logic [RD_W-1:0]   cbm_rd_o,
    input  logic              cbm_busy_i,
    input  logic              cbm_done_i,
    input  logic [DATA_W-1:0] cbm_result_i,
    input  logic [RD_W-1:0]   cbm_rd_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t state;
    logic   ptr;      // pipe that wins the next tie
    logic   pipe_q;   // owner of the multiply currently in flight

    logic can_grant;
    logic gnt0;
    logic gnt1;

    // Ready is combinational so a request is accepted in the same cycle the
    // arbiter becomes free. It is also held low during reset so that every
    // output reads 0 while rst_i is high.
    assign can_grant = (state == S_IDLE) && !flush_i && !cbm_busy_i && !rst_i;
    assign gnt0 = can_grant && req0_valid_i && (!req1_valid_i || !ptr);
    assign gnt1 = can_grant && req1_valid_i && (!req0_valid_i ||  ptr);

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            ptr         <= 1'b0;
            pipe_q      <= 1'b0;
            cbm_start_o <= 1'b0;
            cbm_a_o     <= '0;
            cbm_b_o     <= '0;
            cbm_rd_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_pipe_o  <= 1'b0;
            rsp_rd_o    <= '0;
            rsp_data_o  <= '0;
        end else begin
            cbm_start_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (gnt0 || gnt1) begin
                        cbm_a_o     <= gnt1 ? req1_a_i  : req0_a_i;
                        cbm_b_o     <= gnt1 ? req1_b_i  : req0_b_i;
                        cbm_rd_o    <= gnt1 ? req1_rd_i : req0_rd_i;
                        pipe_q      <= gnt1;
                        ptr         <= ~gnt1;
                        cbm_start_o <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The start pulse is already on the wire this cycle, so a
                    // flush here still leaves one op inside the CBM to drain.
                    state <= flush_i ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (cbm_done_i) begin
                        if (flush_i) begin
                            // Done and flush together: nothing left to drain.
                            state <= S_IDLE;
                        end else begin
                            rsp_valid_o <= 1'b1;
                            rsp_pipe_o  <= pipe_q;
                            // The latched tag is authoritative; the returned
                            // tag is only forwarded when it agrees with it.
                            rsp_rd_o    <= (cbm_rd_i == cbm_rd_o) ? cbm_rd_i : cbm_rd_o;
                            rsp_data_o  <= cbm_result_i;
                            state       <= S_RESP;
                        end
                    end else if (flush_i) begin
                        state <= S_DRAIN;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i || flush_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (cbm_done_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
